// File: rtl/udcounter_arbiter.sv
// udcounter_arbiter: round-robin arbiter/sequencer for a shared up/down counter.
// Two requesters issue load/dec/inc/no-op requests. Each granted request is
// bounds-checked against 0 and LIMIT. A legal request drives the counter mode
// for exactly one cycle, and then the requester is acked. Counter mode encoding
// matches the opcode: 00=preset, 01=down, 10=up, 11=hold.
module udcounter_arbiter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_a_valid,
    input  logic [1:0]       i_a_op,
    input  logic [WIDTH-1:0] i_a_data,
    output logic             o_a_ack,
    input  logic             i_b_valid,
    input  logic [1:0]       i_b_op,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_b_ack,
    output logic             o_nack,
    input  logic [WIDTH-1:0] i_cnt_value,
    output logic [1:0]       o_cnt_mode,
    output logic [WIDTH-1:0] o_cnt_preset,
    output logic             o_err_overflow,
    output logic             o_err_underflow,
    input  logic             i_err_clr
);

    localparam logic [1:0]       OP_LOAD = 2'b00;
    localparam logic [1:0]       OP_DEC  = 2'b01;
    localparam logic [1:0]       OP_INC  = 2'b10;
    localparam logic [1:0]       OP_NOP  = 2'b11;
    localparam logic [WIDTH-1:0] LIM     = WIDTH'(LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_last_b, w_last_b_nxt;     // 1: B won the last contested grant
    logic             r_gnt_b, w_gnt_b_nxt;       // port currently being served
    logic             r_illegal, w_illegal_nxt;   // granted request failed bounds check
    logic             r_ovf_kind, w_ovf_kind_nxt; // rejection is an overflow (vs underflow)
    logic [1:0]       r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_preset, w_preset_nxt;
    logic             r_a_ack, w_a_ack_nxt;
    logic             r_b_ack, w_b_ack_nxt;
    logic             r_nack, w_nack_nxt;
    logic             r_err_ovf, w_err_ovf_nxt;
    logic             r_err_unf, w_err_unf_nxt;

    logic             w_a_win, w_b_win;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_illegal;

    // Arbitration and legality of the request that would be granted this cycle
    always_comb begin
        w_a_win = i_a_valid & (~i_b_valid | r_last_b);
        w_b_win = i_b_valid & ~w_a_win;
        w_op    = w_a_win ? i_a_op   : i_b_op;
        w_data  = w_a_win ? i_a_data : i_b_data;
        case (w_op)
            OP_INC:  w_illegal = (i_cnt_value == LIM);
            OP_DEC:  w_illegal = (i_cnt_value == '0);
            OP_LOAD: w_illegal = (w_data > LIM);
            default: w_illegal = 1'b0;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_b   <= 1'b1;
            r_gnt_b    <= 1'b0;
            r_illegal  <= 1'b0;
            r_ovf_kind <= 1'b0;
            r_mode     <= OP_NOP;
            r_preset   <= '0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_nack     <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_b   <= w_last_b_nxt;
            r_gnt_b    <= w_gnt_b_nxt;
            r_illegal  <= w_illegal_nxt;
            r_ovf_kind <= w_ovf_kind_nxt;
            r_mode     <= w_mode_nxt;
            r_preset   <= w_preset_nxt;
            r_a_ack    <= w_a_ack_nxt;
            r_b_ack    <= w_b_ack_nxt;
            r_nack     <= w_nack_nxt;
            r_err_ovf  <= w_err_ovf_nxt;
            r_err_unf  <= w_err_unf_nxt;
        end
    end

    // Next state and next output values; mode defaults to hold so a
    // non-hold mode never survives more than one cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_last_b_nxt   = r_last_b;
        w_gnt_b_nxt    = r_gnt_b;
        w_illegal_nxt  = r_illegal;
        w_ovf_kind_nxt = r_ovf_kind;
        w_mode_nxt     = OP_NOP;
        w_preset_nxt   = r_preset;
        w_a_ack_nxt    = 1'b0;
        w_b_ack_nxt    = 1'b0;
        w_nack_nxt     = 1'b0;
        w_err_ovf_nxt  = r_err_ovf;
        w_err_unf_nxt  = r_err_unf;

        case (r_state)
            S_IDLE: begin
                if (i_a_valid | i_b_valid) begin
                    w_state_nxt    = S_ISSUE;
                    w_gnt_b_nxt    = w_b_win;
                    w_illegal_nxt  = w_illegal;
                    w_ovf_kind_nxt = (w_op != OP_DEC);
                    // The pointer only moves on contention, so an
                    // uncontested grant never costs the other port its turn
                    if (i_a_valid & i_b_valid)
                        w_last_b_nxt = w_b_win;
                    if (!w_illegal)
                        w_mode_nxt = w_op;
                    if (!w_illegal && w_op == OP_LOAD)
                        w_preset_nxt = w_data;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_ACK;
                w_a_ack_nxt = ~r_gnt_b;
                w_b_ack_nxt = r_gnt_b;
                w_nack_nxt  = r_illegal;
                if (r_illegal & r_ovf_kind)
                    w_err_ovf_nxt = 1'b1;
                if (r_illegal & ~r_ovf_kind)
                    w_err_unf_nxt = 1'b1;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Clear wins over a same-cycle set
        if (i_err_clr) begin
            w_err_ovf_nxt = 1'b0;
            w_err_unf_nxt = 1'b0;
        end
    end

    assign o_a_ack         = r_a_ack;
    assign o_b_ack         = r_b_ack;
    assign o_nack          = r_nack;
    assign o_cnt_mode      = r_mode;
    assign o_cnt_preset    = r_preset;
    assign o_err_overflow  = r_err_ovf;
    assign o_err_underflow = r_err_unf;

endmodule

// File: doc/udcounter_arbiter.md
Name: udcounter_arbiter

Overview:
- Two-port arbiter and sequencer for one shared sync-load, async-reset up/down counter (MC10E136 style; mode 00=preset, 01=down, 10=up, 11=hold).
- Requesters A and B each issue load, increment, decrement or no-op requests over a valid/ack handshake.
- The block grants requesters round-robin and drives the counter's mode and preset pins.
- It bounds-checks every request against 0 and LIMIT and rejects out-of-range requests.
- Used as the stack-pointer/index controller in the datapath.

Parameters:
- WIDTH, 8, counter/data width in bits.
- LIMIT, 255, highest legal counter value; must be ≤ 2^WIDTH-1.

Ports:
- clk  input  1  system clock; counter shares it.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A request pending.
- a_op  input  2  A opcode: 00=load, 01=decrement, 10=increment, 11=no-op/read.
- a_data  input  WIDTH  A load value.
- a_ack  output  1  one-cycle completion pulse to A.
- b_valid  input  1  requester B request pending.
- b_op  input  2  B opcode, same encoding as a_op.
- b_data  input  WIDTH  B load value.
- b_ack  output  1  one-cycle completion pulse to B.
- nack  output  1  high with a_ack/b_ack when the request was rejected.
- cnt_value  input  WIDTH  current counter output.
- cnt_mode  output  2  drives counter mode pins.
- cnt_preset  output  WIDTH  drives counter preset pins.
- err_overflow  output  1  sticky: a rejected increment or load > LIMIT occurred.
- err_underflow  output  1  sticky: a rejected decrement at 0 occurred.
- err_clr  input  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async): state=IDLE, cnt_mode=11, cnt_preset=0, a_ack=b_ack=nack=0, errors=0, round-robin pointer "last granted"=B (so A wins first).
- All outputs are registered. cnt_mode is 11 whenever no operation is issuing.
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - Sample a_valid/b_valid at edge e0.
  - If neither is valid, stay in IDLE.
  - If exactly one is valid, grant it.
  - If both are valid, grant the requester not granted last; update the pointer.
- Legality check, evaluated in IDLE on cnt_value and the granted op:
  - Increment is illegal if cnt_value == LIMIT.
  - Decrement is illegal if cnt_value == 0.
  - Load is illegal if data > LIMIT.
  - No-op is always legal.
- Legal load/increment/decrement:
  - At e0, register cnt_mode = op and cnt_preset = data (load only; otherwise unchanged). Go to ISSUE.
  - At e1, the counter applies the op. The block sets cnt_mode=11, pulses the granted ack=1 (nack=0), and goes to ACK.
  - cnt_value shows the new value within the ack cycle.
- Legal no-op: at e0 go to ISSUE with cnt_mode kept at 11. Ack at e1 as above; the counter is unchanged.
- Illegal request:
  - At e0 go to ISSUE with cnt_mode=11.
  - At e1, pulse the granted ack with nack=1 and set the matching sticky error (load>LIMIT or increment at LIMIT → overflow; decrement at 0 → underflow).
  - The counter is never modified.
- ACK: the ack drops at e2 and the state returns to IDLE. New arbitration happens no earlier than e3. Requesters must drop valid on the edge where they see ack. Throughput is 1 request per 3 cycles per port.
- Request latency: valid sampled at e0 → ack high during cycle e1–e2.
- Data and op are sampled only at grant. Changes on the ungranted port while busy are ignored. A valid held by the losing port is served next grant.
- err_clr has priority over a same-cycle error set, so the error reads 0.
- Reset mid-operation forces IDLE and hold mode; any in-flight ack is lost. The counter's own reset is separate; the block relies only on cnt_value.
- cnt_mode is never 00/01/10 for more than one consecutive cycle.

Test Plan:
- Reset, then A load 0x10 → cnt_mode=00, cnt_preset=0x10 one cycle; a_ack next cycle with cnt_value=0x10, nack=0; cnt_mode back to 11.
- A and B both valid each turn with increments from 0x10 → grants alternate A,B,A,B; cnt_value ends 0x14; no cycle with both acks high.
- cnt_value=0, B decrement → b_ack with nack=1, err_underflow=1, cnt_mode stays 11, cnt_value stays 0; err_clr → err_underflow=0.
- LIMIT=0x20, counter at 0x20, A increment → nack=1, err_overflow=1; A load 0x21 → nack=1; A load 0x20 → nack=0.
- A no-op → a_ack after 1 cycle, cnt_mode never leaves 11, cnt_value unchanged.
- Assert reset in the ISSUE cycle of an increment → cnt_mode=11, no ack, state IDLE; after release, A is granted first.
